// File: rtl/exc_flush_ctrl_pkg.sv
// exc_flush_ctrl_pkg: ExcCodes, CP0 Status bit positions, FSM states and the interrupt-pending helper.
package exc_flush_ctrl_pkg;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;
    localparam int EXV_W = 7;
    localparam logic [4:0] EX_INT = 5'h00;
    localparam logic [4:0] EX_ADEL = 5'h04;
    localparam logic [4:0] EX_ADES = 5'h05;
    localparam logic [4:0] EX_SYS = 5'h08;
    localparam logic [4:0] EX_BP = 5'h09;
    localparam logic [4:0] EX_RI = 5'h0a;
    localparam logic [4:0] EX_OV = 5'h0c;
    localparam int ST_IE = 0;
    localparam int ST_EXL = 1;

    typedef enum logic {IDLE, REDIR} state_t;

    function automatic logic int_pending(input logic [31:0] status, input logic [31:0] cause);
        return status[ST_IE] & ~status[ST_EXL] & |(status[15:8] & cause[15:8]);
    endfunction
endpackage

// File: rtl/exc_flush_ctrl_if.sv
// exc_flush_ctrl_if: WB/CP0 inputs, CP0 commit strobes and fetch redirect handshake.
// EXC_STAT_CNT_EN adds the exc_cnt/int_cnt statistics outputs.
interface exc_flush_ctrl_if;
    import exc_flush_ctrl_pkg::*;
    logic             ws_valid;
    logic [31:0]      ws_pc;
    logic             ws_bd;
    logic [EXV_W-1:0] ws_ex_vec;
    logic             ws_eret;
    logic [31:0]      c0_status;
    logic [31:0]      c0_cause;
    logic [31:0]      c0_epc;
    logic             wb_ex;
    logic [4:0]       wb_excode;
    logic             wb_bd;
    logic [31:0]      wb_pc;
    logic             eret_flush;
    logic             flush;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             redirect_ready;
`ifdef EXC_STAT_CNT_EN
    logic [31:0]      exc_cnt;
    logic [31:0]      int_cnt;
`endif

    modport master (
        output ws_valid, ws_pc, ws_bd, ws_ex_vec, ws_eret, c0_status, c0_cause, c0_epc, redirect_ready,
        input  wb_ex, wb_excode, wb_bd, wb_pc, eret_flush, flush, redirect_valid, redirect_pc
`ifdef EXC_STAT_CNT_EN
        , exc_cnt, int_cnt
`endif
    );

    modport slave (
        input  ws_valid, ws_pc, ws_bd, ws_ex_vec, ws_eret, c0_status, c0_cause, c0_epc, redirect_ready,
        output wb_ex, wb_excode, wb_bd, wb_pc, eret_flush, flush, redirect_valid, redirect_pc
`ifdef EXC_STAT_CNT_EN
        , exc_cnt, int_cnt
`endif
    );
endinterface

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: picks the highest-priority cause from the WB exception flags and the pending interrupt.
module exc_prio_enc
    import exc_flush_ctrl_pkg::*;
(
    input  logic [EXV_W-1:0] ex_vec,
    input  logic             int_pend,
    output logic             any,
    output logic [4:0]       excode
);
    assign any = int_pend | (|ex_vec);
    // Load/store AdEL ranks below the fetch-side causes, hence the split AdEL entries.
    always_comb
        excode = int_pend  ? EX_INT  :
                 ex_vec[0] ? EX_ADEL :
                 ex_vec[1] ? EX_RI   :
                 ex_vec[2] ? EX_OV   :
                 ex_vec[3] ? EX_SYS  :
                 ex_vec[4] ? EX_BP   :
                 ex_vec[5] ? EX_ADEL :
                 ex_vec[6] ? EX_ADES : EX_INT;
endmodule

// File: rtl/exc_flush_ctrl.sv
// exc_flush_ctrl: WB-stage exception/ERET sequencer driving CP0 strobes, flush and the fetch redirect.
// EXC_STAT_CNT_EN: adds exception/interrupt statistics counters.
module exc_flush_ctrl
    import exc_flush_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input logic             clk,
    input logic             reset,
    exc_flush_ctrl_if.slave bus
);
    state_t      state;
    logic [31:0] tgt;
    logic        int_pend, any, idle, take_ex, take_eret;
    logic [4:0]  code;
    logic        unused_bits;

    assign unused_bits = ^{bus.c0_status[31:16], bus.c0_status[7:2], bus.c0_cause[31:16], bus.c0_cause[7:0]};
    assign int_pend = int_pending(bus.c0_status, bus.c0_cause);

    exc_prio_enc u_enc (.ex_vec(bus.ws_ex_vec), .int_pend(int_pend), .any(any), .excode(code));

    // Outputs are forced low while reset is asserted so a reset in REDIR drops the redirect at once.
    assign idle = (state == IDLE) & ~reset;
    assign take_ex = idle & bus.ws_valid & any;
    assign take_eret = idle & bus.ws_valid & bus.ws_eret & ~any;

    assign bus.wb_ex = take_ex;
    assign bus.wb_excode = take_ex ? code : 5'd0;
    assign bus.wb_bd = take_ex & bus.ws_bd;
    assign bus.wb_pc = take_ex ? bus.ws_pc : 32'd0;
    assign bus.eret_flush = take_eret;
    assign bus.redirect_valid = (state == REDIR) & ~reset;
    assign bus.flush = take_ex | take_eret | bus.redirect_valid;
    assign bus.redirect_pc = tgt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            tgt <= 32'd0;
        end else if (take_ex | take_eret) begin
            state <= REDIR;
            tgt <= take_ex ? EXC_VECTOR : bus.c0_epc;
        end else if (state == REDIR && bus.redirect_ready) begin
            state <= IDLE;
        end
    end

`ifdef EXC_STAT_CNT_EN
    logic [31:0] exc_cnt_q, int_cnt_q;
    assign bus.exc_cnt = exc_cnt_q;
    assign bus.int_cnt = int_cnt_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            exc_cnt_q <= 32'd0;
            int_cnt_q <= 32'd0;
        end else if (take_ex) begin
            exc_cnt_q <= exc_cnt_q + 32'd1;
            if (code == EX_INT) int_cnt_q <= int_cnt_q + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_exc_flush_ctrl.sv
// tb_exc_flush_ctrl: directed vectors for exc_flush_ctrl with hand-computed expectations.
module tb_exc_flush_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    exc_flush_ctrl_if bus ();
    exc_flush_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic fire(input logic [6:0] vec, input logic [31:0] pc, input logic bd, input logic eret);
        bus.ws_valid = 1'b1;
        bus.ws_ex_vec = vec;
        bus.ws_pc = pc;
        bus.ws_bd = bd;
        bus.ws_eret = eret;
    endtask

    task automatic finish_redir();
        step();
        bus.ws_valid = 1'b0;
        bus.ws_ex_vec = '0;
        bus.ws_eret = 1'b0;
        bus.redirect_ready = 1'b1;
        step();
        bus.redirect_ready = 1'b0;
        mid();
        chk("redir_done", {31'd0, bus.redirect_valid}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.ws_valid = 1'b0;
        bus.ws_pc = '0;
        bus.ws_bd = 1'b0;
        bus.ws_ex_vec = '0;
        bus.ws_eret = 1'b0;
        bus.c0_status = '0;
        bus.c0_cause = '0;
        bus.c0_epc = '0;
        bus.redirect_ready = 1'b0;
        step();
        step();
        mid();
        chk("rst_wb_ex", {31'd0, bus.wb_ex}, 32'd0);
        chk("rst_flush", {31'd0, bus.flush}, 32'd0);
        chk("rst_rvalid", {31'd0, bus.redirect_valid}, 32'd0);
        chk("rst_rpc", bus.redirect_pc, 32'd0);
        step();
        reset = 1'b0;

        // RI, zero-latency commit and exception vector target
        fire(7'b0000010, 32'hBFC0_0100, 1'b0, 1'b0);
        mid();
        chk("ri_wb_ex", {31'd0, bus.wb_ex}, 32'd1);
        chk("ri_code", {27'd0, bus.wb_excode}, 32'h0a);
        chk("ri_pc", bus.wb_pc, 32'hBFC0_0100);
        chk("ri_bd", {31'd0, bus.wb_bd}, 32'd0);
        chk("ri_flush", {31'd0, bus.flush}, 32'd1);
        chk("ri_rvalid0", {31'd0, bus.redirect_valid}, 32'd0);
        step();
        mid();
        chk("ri_pulse", {31'd0, bus.wb_ex}, 32'd0);
        chk("ri_rvalid", {31'd0, bus.redirect_valid}, 32'd1);
        chk("ri_rpc", bus.redirect_pc, 32'hBFC0_0380);
        chk("ri_rflush", {31'd0, bus.flush}, 32'd1);
        finish_redir();

        // Ov beats Sys, BD passes through
        step();
        fire(7'b0001100, 32'hBFC0_0200, 1'b1, 1'b0);
        mid();
        chk("ovsys_code", {27'd0, bus.wb_excode}, 32'h0c);
        chk("ovsys_bd", {31'd0, bus.wb_bd}, 32'd1);
        finish_redir();

        // Interrupt beats Sys; EXL masks it
        step();
        bus.c0_status = 32'h0000_FF01;
        bus.c0_cause = 32'h0000_8000;
        fire(7'b0001000, 32'hBFC0_0300, 1'b0, 1'b0);
        mid();
        chk("int_wb_ex", {31'd0, bus.wb_ex}, 32'd1);
        chk("int_code", {27'd0, bus.wb_excode}, 32'h00);
        finish_redir();
        step();
        bus.c0_status = 32'h0000_FF03;
        fire(7'b0001000, 32'hBFC0_0304, 1'b0, 1'b0);
        mid();
        chk("exl_code", {27'd0, bus.wb_excode}, 32'h08);
        finish_redir();

        // Interrupt waits for a valid WB instruction
        step();
        bus.c0_status = 32'h0000_FF01;
        mid();
        chk("int_defer", {31'd0, bus.wb_ex}, 32'd0);
        step();
        fire(7'b0000000, 32'hBFC0_0400, 1'b0, 1'b0);
        mid();
        chk("int_take", {31'd0, bus.wb_ex}, 32'd1);
        chk("int_take_code", {27'd0, bus.wb_excode}, 32'h00);
        chk("int_take_pc", bus.wb_pc, 32'hBFC0_0400);
        finish_redir();

        // ERET alone, then ERET losing to Ov
        step();
        bus.c0_status = '0;
        bus.c0_cause = '0;
        bus.c0_epc = 32'hBFC0_1234;
        fire(7'b0000000, 32'hBFC0_0500, 1'b0, 1'b1);
        mid();
        chk("eret_flush", {31'd0, bus.eret_flush}, 32'd1);
        chk("eret_wb_ex", {31'd0, bus.wb_ex}, 32'd0);
        chk("eret_fl", {31'd0, bus.flush}, 32'd1);
        step();
        mid();
        chk("eret_pulse", {31'd0, bus.eret_flush}, 32'd0);
        chk("eret_rpc", bus.redirect_pc, 32'hBFC0_1234);
        finish_redir();
        step();
        fire(7'b0000100, 32'hBFC0_0600, 1'b0, 1'b1);
        mid();
        chk("eov_wb_ex", {31'd0, bus.wb_ex}, 32'd1);
        chk("eov_code", {27'd0, bus.wb_excode}, 32'h0c);
        chk("eov_eret", {31'd0, bus.eret_flush}, 32'd0);
        step();
        mid();
        chk("eov_rpc", bus.redirect_pc, 32'hBFC0_0380);
        finish_redir();

        // Stalled redirect; ready in the entry cycle is ignored
        step();
        bus.redirect_ready = 1'b1;
        fire(7'b0000010, 32'hBFC0_0700, 1'b0, 1'b0);
        step();
        bus.redirect_ready = 1'b0;
        fire(7'b1000000, 32'hBFC0_0704, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            mid();
            chk("stall_rvalid", {31'd0, bus.redirect_valid}, 32'd1);
            chk("stall_flush", {31'd0, bus.flush}, 32'd1);
            chk("stall_wb_ex", {31'd0, bus.wb_ex}, 32'd0);
            step();
        end
        bus.redirect_ready = 1'b1;
        mid();
        chk("stall_last", {31'd0, bus.redirect_valid}, 32'd1);
        step();
        bus.redirect_ready = 1'b0;
        mid();
        chk("stall_idle", {31'd0, bus.redirect_valid}, 32'd0);
        chk("stall_ades", {27'd0, bus.wb_excode}, 32'h05);
        chk("stall_ades_ex", {31'd0, bus.wb_ex}, 32'd1);
        finish_redir();

        // Reset during REDIR
        step();
        fire(7'b0010000, 32'hBFC0_0800, 1'b0, 1'b0);
        step();
        bus.ws_valid = 1'b0;
        mid();
        chk("pre_rst_rvalid", {31'd0, bus.redirect_valid}, 32'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        mid();
        chk("rst_redir_rvalid", {31'd0, bus.redirect_valid}, 32'd0);
        chk("rst_redir_flush", {31'd0, bus.flush}, 32'd0);
        chk("rst_redir_rpc", bus.redirect_pc, 32'd0);
        chk("rst_redir_wb_ex", {31'd0, bus.wb_ex}, 32'd0);
        step();
        fire(7'b0010000, 32'hBFC0_0900, 1'b0, 1'b0);
        mid();
        chk("post_rst_take", {31'd0, bus.wb_ex}, 32'd1);
        chk("post_rst_code", {27'd0, bus.wb_excode}, 32'h09);
        finish_redir();

`ifdef EXC_STAT_CNT_EN
        step();
        fire(7'b0000001, 32'hBFC0_0A00, 1'b0, 1'b0);
        finish_redir();
        step();
        fire(7'b0100000, 32'hBFC0_0A04, 1'b0, 1'b0);
        finish_redir();
        chk("exc_cnt", bus.exc_cnt, 32'd3);
        chk("int_cnt", bus.int_cnt, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
